ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ready handshake.
- Presents one instruction at a time, with its opcode field, to the control and datapath.
- On the datapath's advance strobe, selects the next PC: sequential, taken branch, or jump.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- o_imem_req  output  1  fetch request to instruction memory.
- o_imem_addr  output  32  byte address of the requested word; bits [1:0] always 2'b00.
- i_imem_ready  input  1  memory accepts the request and returns data in the same cycle.
- i_imem_rdata  input  32  instruction word, valid when o_imem_req && i_imem_ready.
- o_instr_valid  output  1  o_instr, o_opcode and o_pc hold a fetched instruction.
- o_instr  output  32  current instruction word.
- o_opcode  output  6  o_instr[31:26]; drives the control decoder's opcode input.
- o_pc  output  32  address of o_instr.
- o_pc_plus4  output  32  o_pc + 4, mod 2^32.
- i_advance  input  1  datapath has finished the current instruction; consume it and fetch the next.
- i_branch_taken  input  1  branch condition already qualified (branch AND zero-result).
- i_branch_imm  input  16  branch offset in words, signed.
- i_jump  input  1  current instruction is J.
- i_jump_target  input  26  J-format target field.

Behaviour:
- Reset (async, rst_n low):
  - State FETCH, pc = RESET_PC.
  - o_imem_req = 0, o_instr_valid = 0, o_instr = 0 (NOP), o_pc = RESET_PC.
  - Asserting rst_n mid-handshake drops the request immediately; the in-flight response is discarded.
- FSM states:
  - FETCH:
    - o_imem_req = 1 (0 only while in reset), o_imem_addr = pc.
    - Request and address stay stable while i_imem_ready = 0.
    - On a clock edge with ready = 1: o_instr <= i_imem_rdata, o_instr_valid <= 1, go to HOLD.
  - HOLD:
    - o_imem_req = 0; outputs stay frozen until i_advance = 1.
    - On a clock edge with i_advance = 1: pc <= next_pc, o_instr_valid <= 0, go to FETCH.
- next_pc (combinational from the current o_pc and redirect inputs, sampled only in HOLD with i_advance):
  - i_jump = 1: {pc_plus4[31:28], i_jump_target, 2'b00}.
  - else i_branch_taken = 1: pc_plus4 + (sign_extend(i_branch_imm) << 2), mod 2^32.
  - else: pc_plus4.
  - Jump has priority over branch when both are asserted.
- Inputs ignored outside their use:
  - i_advance is ignored in FETCH.
  - i_branch_taken, i_jump and the redirect operands are ignored unless i_advance is high in HOLD.
- Latency and throughput:
  - First request is in the first cycle after rst_n deasserts.
  - With zero-wait memory: valid one cycle after the request; peak rate one instruction per 2 cycles.
  - Each memory wait cycle adds one cycle.
- Wrap-around: PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000. Negative offsets wrap the same way.
- o_opcode is o_instr[31:26] by construction, registered together with o_instr. Downstream must qualify the control outputs with o_instr_valid.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum {FETCH, HOLD}.
  - Opcode constants: OP_RTYPE 6'b000000, OP_J 6'b000010, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_LW 6'b100011, OP_SW 6'b101011.
  - NOP word 32'h0000_0000.
- One combinational sub-module, ifetch_next_pc: inputs pc_plus4 and the redirect fields, output next_pc. Unit-testable in isolation.

Test Plan:
- Reset then zero-wait memory returning 32'h8C08_0004 at addr 0:
  - req in the first cycle after release, addr 0.
  - Valid next cycle; o_opcode = 6'b100011, o_pc_plus4 = 4.
- Memory holds ready low for 3 cycles:
  - req and addr stay constant throughout.
  - Valid rises exactly one cycle after ready pulses.
  - An i_advance pulse during the wait has no effect.
- Sequential advance:
  - Advance with no redirect at pc 0 -> next fetch addr 4.
  - Advance with no redirect at pc 32'hFFFF_FFFC -> next fetch addr 0.
- Branch at pc 32'h0000_0010:
  - taken, imm 16'hFFFC -> next addr 32'h0000_0004.
  - taken, imm 16'h0003 -> next addr 32'h0000_0020.
  - not taken -> next addr 32'h0000_0014.
- Jump at pc 32'h4000_0000 with target 26'h000_0040, branch_taken also high -> next addr 32'h4000_0100 (jump wins).
- rst_n pulsed low while in FETCH with ready low:
  - req drops asynchronously; valid stays 0.
  - After release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, primary opcode values and the NOP encoding.
package cpu_pkg;

  typedef enum logic {
    FETCH,
    HOLD
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC selection: jump beats taken branch, which beats sequential fall-through.
module ifetch_next_pc (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] next_pc
);

  // Word offset, sign-extended and scaled to bytes.
  logic [31:0] br_off;
  assign br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: requests one word per PC, holds it for the datapath until
// advance, then moves the PC to the sequential, branch or jump successor.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_advance,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_imm,
  input  logic        i_jump,
  input  logic [25:0] i_jump_target
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  ifetch_next_pc u_next_pc (
    .pc_plus4     (pc_plus4),
    .branch_taken (i_branch_taken),
    .branch_imm   (i_branch_imm),
    .jump         (i_jump),
    .jump_target  (i_jump_target),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      FETCH: begin
        if (i_imem_ready) begin
          instr_d = i_imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Gating with rst_n drops the request the moment reset asserts, not at the next edge.
  always_comb begin
    o_imem_req    = rst_n && (state_q == FETCH);
    o_imem_addr   = {pc_q[31:2], 2'b00};
    o_instr_valid = valid_q;
    o_instr       = instr_q;
    o_opcode      = instr_q[31:26];
    o_pc          = pc_q;
    o_pc_plus4    = pc_plus4;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed sequences, a redirect table and a randomized
// run against a transaction-level fetch model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready, advance, br, jump;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic [31:0] rdata;

  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4;
  logic [5:0]  opcode;

  logic        h_req, h_valid;
  logic [31:0] h_addr, h_instr, h_pc, h_pc4;
  logic [5:0]  h_opcode;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  assign rdata = mem_word(addr);

  ifetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ready(ready), .i_imem_rdata(rdata),
    .o_instr_valid(valid), .o_instr(instr), .o_opcode(opcode), .o_pc(pc), .o_pc_plus4(pc4),
    .i_advance(advance), .i_branch_taken(br), .i_branch_imm(imm),
    .i_jump(jump), .i_jump_target(tgt)
  );

  // Second instance in the 0x4xxx_xxxx region so the jump-region bits are exercised.
  ifetch_unit #(.RESET_PC(32'h4000_0000)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(h_req), .o_imem_addr(h_addr), .i_imem_ready(ready), .i_imem_rdata(rdata),
    .o_instr_valid(h_valid), .o_instr(h_instr), .o_opcode(h_opcode), .o_pc(h_pc),
    .o_pc_plus4(h_pc4),
    .i_advance(advance), .i_branch_taken(br), .i_branch_imm(imm),
    .i_jump(jump), .i_jump_target(tgt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in FETCH with ready high: checks the request, then the presented instruction.
  task automatic fetch_check(input string tag, input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    chk({tag, " req"}, 32'(req), 32'd1);
    chk({tag, " addr"}, addr, a);
    next_neg();
    chk({tag, " valid"}, 32'(valid), 32'd1);
    chk({tag, " pc"}, pc, a);
    chk({tag, " pc_plus4"}, pc4, a + 32'd4);
    chk({tag, " instr"}, instr, w);
    chk({tag, " opcode"}, 32'(opcode), 32'(w[31:26]));
    chk({tag, " req_low"}, 32'(req), 32'd0);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j,
                                           input logic [25:0] t, input logic b,
                                           input logic [15:0] i);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], t, 2'b00};
    off = int'($signed(i));
    if (b) return p4 + 32'(off * 4);
    return p4;
  endfunction

  typedef struct {
    logic        jump;
    logic [25:0] tgt;
    logic        br;
    logic [15:0] imm;
    logic [31:0] exp;
  } redir_t;

  redir_t tbl[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_pc, m_instr;
    logic        m_valid;

    // Chain starting from pc 4; each row's start pc is the previous row's target.
    tbl[0] = '{1'b0, 26'h0,       1'b1, 16'hFFFD, 32'hFFFF_FFFC};
    tbl[1] = '{1'b0, 26'h0,       1'b0, 16'h0000, 32'h0000_0000};
    tbl[2] = '{1'b1, 26'h4,       1'b0, 16'h0000, 32'h0000_0010};
    tbl[3] = '{1'b0, 26'h0,       1'b1, 16'hFFFC, 32'h0000_0004};
    tbl[4] = '{1'b1, 26'h4,       1'b0, 16'h0000, 32'h0000_0010};
    tbl[5] = '{1'b0, 26'h0,       1'b1, 16'h0003, 32'h0000_0020};
    tbl[6] = '{1'b1, 26'h4,       1'b0, 16'h0000, 32'h0000_0010};
    tbl[7] = '{1'b0, 26'h0,       1'b0, 16'h7777, 32'h0000_0014};
    tbl[8] = '{1'b0, 26'h0,       1'b1, 16'h8000, 32'hFFFE_0018};
    tbl[9] = '{1'b1, 26'h3FF_FFFF, 1'b1, 16'h0001, 32'hFFFF_FFFC};

    ready = 1'b1; advance = 1'b0; br = 1'b0; jump = 1'b0; imm = '0; tgt = '0;

    #12;
    chk("reset req", 32'(req), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset instr", instr, 32'h0);
    chk("reset pc", pc, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    fetch_check("first", 32'h0);
    chk("first opcode lw", 32'(opcode), 32'h23);

    // Sequential advance into a wait-stated fetch, with a stray advance/jump during the wait.
    advance = 1'b1;
    next_neg();
    advance = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_neg();
      chk("wait req", 32'(req), 32'd1);
      chk("wait addr", addr, 32'h4);
      chk("wait valid", 32'(valid), 32'd0);
      advance = (i == 0);
      jump = (i == 0);
      tgt = 26'($urandom);
    end
    advance = 1'b0; jump = 1'b0;
    ready = 1'b1;
    next_neg();
    chk("wait done valid", 32'(valid), 32'd1);
    chk("wait done pc", pc, 32'h4);
    chk("wait done instr", instr, mem_word(32'h4));

    foreach (tbl[k]) begin
      jump = tbl[k].jump; tgt = tbl[k].tgt; br = tbl[k].br; imm = tbl[k].imm;
      advance = 1'b1;
      next_neg();
      advance = 1'b0; jump = 1'b0; br = 1'b0; imm = '0; tgt = '0;
      fetch_check($sformatf("redir%0d", k), tbl[k].exp);
    end

    // Wrap to 0, then reset mid-fetch with memory stalled.
    ready = 1'b0;
    advance = 1'b1;
    next_neg();
    advance = 1'b0;
    chk("wrap addr", addr, 32'h0);
    chk("wrap req", 32'(req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async req", 32'(req), 32'd0);
    chk("async hi req", 32'(h_req), 32'd0);
    chk("async valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart hi addr", h_addr, 32'h4000_0000);
    ready = 1'b1;
    fetch_check("restart", 32'h0);
    chk("hi valid", 32'(h_valid), 32'd1);

    jump = 1'b1; tgt = 26'h000_0040; br = 1'b1; imm = 16'h0010;
    advance = 1'b1;
    next_neg();
    advance = 1'b0; jump = 1'b0; br = 1'b0;
    chk("jump wins hi", h_addr, 32'h4000_0100);
    chk("jump wins lo", addr, 32'h0000_0100);

    // Randomized run against the transaction model: one word fetched per pc, held until advance.
    m_pc = 32'h100;
    m_valid = 1'b0;
    m_instr = '0;
    for (int n = 0; n < 400; n++) begin
      chk("rnd req", 32'(req), 32'(!m_valid));
      chk("rnd addr", addr, m_pc);
      chk("rnd valid", 32'(valid), 32'(m_valid));
      chk("rnd pc", pc, m_pc);
      if (m_valid) chk("rnd instr", instr, m_instr);
      ready   = ($urandom_range(2) != 0);
      advance = $urandom_range(1) == 1;
      jump    = ($urandom_range(3) == 0);
      br      = ($urandom_range(2) == 0);
      imm     = 16'($urandom);
      tgt     = 26'($urandom);
      if (!m_valid) begin
        if (ready) begin
          m_instr = mem_word(m_pc);
          m_valid = 1'b1;
        end
      end else if (advance) begin
        m_pc = ref_next(m_pc, jump, tgt, br, imm);
        m_valid = 1'b0;
      end
      next_neg();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
